// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory path.
// Holds the line, beat and address widths, the adaptor state encoding,
// the line/beat types, and a helper that aligns an address to its line.
package cache_pkg;

  localparam int LINE_W  = 256;                  // cache line width in bits
  localparam int BURST_W = 64;                   // memory bus beat width in bits
  localparam int ADDR_W  = 32;                   // physical address width
  localparam int BEATS   = LINE_W / BURST_W;     // beats per line (4)
  localparam int OFS_W   = $clog2(LINE_W / 8);   // byte-offset bits within a line (5)
  localparam int CNT_W   = $clog2(BEATS);        // beat counter width (2)

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;

  typedef logic [LINE_W-1:0]  cacheline_t;
  typedef logic [BURST_W-1:0] beat_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // Clear the byte offset so the memory burst starts at the line boundary.
  function automatic addr_t line_base(input addr_t addr);
    return {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Bridges the cache's 256-bit pmem port to a 64-bit burst memory bus.
// A line read gathers 4 incoming beats into line_o; a line write scatters
// the latched line into 4 outgoing beats on burst_o.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   line_i     line to write (cache pmem_wdata)
//   line_o     assembled read line (cache pmem_rdata)
//   address_i  line address from the cache
//   read_i     cache line-read request, held until resp_o
//   write_i    cache line-write request, held until resp_o
//   resp_o     one-cycle completion pulse to the cache
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned burst base address to memory
//   read_o     memory read request
//   write_o    memory write request
//   resp_i     memory beat valid/accept, one beat per high cycle
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  adaptor_state_t           state;
  logic [CNT_W-1:0]         beat_cnt;
  beat_t [BEATS-1:0]        wbuf;    // write line, one element per beat
  beat_t [BEATS-1:0]        line_q;  // read assembly register

  assign line_o  = line_q;
  // The memory sees the beat selected by the counter with no extra delay,
  // so advancing the counter on accept immediately presents the next beat.
  assign burst_o = wbuf[beat_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      line_q    <= '0;
      // NOTE: the data buffers are plain flops, not a RAM, so clearing them
      // costs nothing structural and gives burst_o/line_o a defined reset value.
      wbuf      <= '0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block wins,
      // and every read below sees the pre-edge value.
      resp_o <= 1'b0;

      unique case (state)
        IDLE: begin
          // Read has priority if the cache ever raises both requests.
          if (read_i) begin
            address_o <= line_base(address_i);
            read_o    <= 1'b1;
            state     <= READ;
          end else if (write_i) begin
            address_o <= line_base(address_i);
            wbuf      <= line_i;
            write_o   <= 1'b1;
            state     <= WRITE;
          end
        end

        READ: begin
          if (resp_i) begin
            line_q[beat_cnt] <= burst_i;
            // The counter parks on the last beat and is cleared in DONE,
            // so it never relies on 2-bit overflow to return to zero.
            if (beat_cnt == LAST_BEAT) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            if (beat_cnt == LAST_BEAT) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          // The cache still holds its request this cycle; returning to IDLE
          // unconditionally keeps that stale request from retriggering.
          beat_cnt <= '0;
          state    <= IDLE;
        end

        default: begin
          beat_cnt <= '0;
          read_o   <= 1'b0;
          write_o  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Testbench for cacheline_adaptor.
// The reference model is a line-level view: a line is four beats, beat k is
// line[64k +: 64], a transfer completes the cycle after its fourth accepted
// beat, and line_o keeps the last completed read line.
module tb_cacheline_adaptor;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  cacheline_t   line_i;
  cacheline_t   line_o;
  addr_t        address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  beat_t        burst_i;
  beat_t        burst_o;
  addr_t        address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_pass   = 0;
  cacheline_t last_line;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic cacheline_t rand_line();
    cacheline_t l;
    for (int w = 0; w < LINE_W / 32; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  function automatic addr_t align(input addr_t a);
    return a - (a % (LINE_W / 8));
  endfunction

  // Drives resp_i for one transfer. For reads, beat k of 'line' is offered on
  // burst_i; for writes, burst_o is compared against beat k. Stops after four
  // accepted beats (now sitting in the DONE cycle), or early after
  // abort_after beats when abort_after is nonzero.
  task automatic run_beats(input bit is_write, input cacheline_t line,
                           input bit use_pat, input logic [31:0] pat,
                           input int abort_after, output int ncyc);
    int b = 0;
    int i = 0;
    bit r;
    ncyc = 0;
    while (b < BEATS && ncyc < 64 && !(abort_after != 0 && b >= abort_after)) begin
      if (is_write) check("burst_o beat", burst_o, line[BURST_W*b +: BURST_W]);
      else if (b == 0) check("line_o held before beat 0", line_o, last_line);
      if (use_pat) r = (i < 32) ? pat[i] : 1'b0;
      else r = ($urandom_range(0, 2) != 0);
      i++;
      resp_i  = r;
      burst_i = r ? line[BURST_W*b +: BURST_W] : beat_t'({$urandom, $urandom});
      if (r) b++;
      tick();
      ncyc++;
      resp_i = 1'b0;
      if (!is_write && r)
        check("line_o beat landed", line_o[BURST_W*(b-1) +: BURST_W],
              line[BURST_W*(b-1) +: BURST_W]);
      if (b < BEATS) begin
        check(is_write ? "write_o busy" : "read_o busy", is_write ? write_o : read_o, 1'b1);
        check(is_write ? "read_o idle in write" : "write_o idle in read",
              is_write ? read_o : write_o, 1'b0);
        check("resp_o early", resp_o, 1'b0);
      end
    end
    if (abort_after == 0 && b < BEATS) check("beat budget expired", b, BEATS);
  endtask

  task automatic do_read(input addr_t addr, input cacheline_t line, input bit use_pat,
                         input logic [31:0] pat, input bit also_write,
                         input bit hold_extra, output int ncyc);
    address_i = addr;
    line_i    = rand_line();
    read_i    = 1'b1;
    write_i   = also_write;
    if (also_write)
      $display("protocol error: read_i and write_i both high at %0t", $time);
    tick();
    check("read address_o", address_o, align(addr));
    check("read_o on latch", read_o, 1'b1);
    check("write_o on read latch", write_o, 1'b0);
    address_i = $urandom;
    line_i    = rand_line();
    run_beats(1'b0, line, use_pat, pat, 0, ncyc);
    check("read resp_o", resp_o, 1'b1);
    check("read_o in DONE", read_o, 1'b0);
    check("write_o in DONE", write_o, 1'b0);
    check("read line_o", line_o, line);
    last_line = line;
    if (!hold_extra) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    tick();
    check("resp_o single pulse", resp_o, 1'b0);
    check("read_o in IDLE", read_o, 1'b0);
  endtask

  task automatic do_write(input addr_t addr, input cacheline_t line, input bit use_pat,
                          input logic [31:0] pat, input int abort_after);
    int ncyc;
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = 1'b0;
    tick();
    check("write address_o", address_o, align(addr));
    check("write_o on latch", write_o, 1'b1);
    check("read_o on write latch", read_o, 1'b0);
    address_i = $urandom;
    line_i    = rand_line();
    run_beats(1'b1, line, use_pat, pat, abort_after, ncyc);
    if (abort_after != 0) begin
      rst     = 1'b1;
      write_i = 1'b0;
      tick();
      check("abort write_o", write_o, 1'b0);
      check("abort resp_o", resp_o, 1'b0);
      check("abort read_o", read_o, 1'b0);
      check("abort address_o", address_o, '0);
      check("abort burst_o", burst_o, '0);
      rst       = 1'b0;
      last_line = '0;
      return;
    end
    check("write resp_o", resp_o, 1'b1);
    check("write_o in DONE", write_o, 1'b0);
    check("line_o untouched by write", line_o, last_line);
    write_i = 1'b0;
    tick();
    check("write resp_o single pulse", resp_o, 1'b0);
    check("write_o in IDLE", write_o, 1'b0);
  endtask

  initial begin
    int ncyc;
    cacheline_t l;

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    last_line = '0;
    tick();
    tick();
    check("reset resp_o", resp_o, 1'b0);
    check("reset read_o", read_o, 1'b0);
    check("reset write_o", write_o, 1'b0);
    check("reset line_o", line_o, '0);
    check("reset burst_o", burst_o, '0);
    check("reset address_o", address_o, '0);
    rst = 1'b0;
    tick();

    // T1: back-to-back beats, minimum latency
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, l, 1'b1, 32'hF, 1'b0, 1'b0, ncyc);
    check("T1 resp cycle", ncyc + 2, 6);

    // T2: write scatter in order
    do_write(32'h0000_8040, {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                             64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000},
             1'b1, 32'hF, 0);

    // T3: stalls between beats (1,0,0,1,1,0,1)
    do_read(32'hABCD_EF1F, rand_line(), 1'b1, 32'b1011001, 1'b0, 1'b0, ncyc);
    check("T3 beat cycles", ncyc, 7);

    // T4: request held through DONE plus one cycle; the second read only
    // starts from IDLE.
    do_read(32'h0000_2000, rand_line(), 1'b1, 32'hF, 1'b0, 1'b1, ncyc);
    tick();
    check("T4 second read_o", read_o, 1'b1);
    check("T4 no extra resp_o", resp_o, 1'b0);
    l = rand_line();
    run_beats(1'b0, l, 1'b1, 32'hF, 0, ncyc);
    check("T4 second resp_o", resp_o, 1'b1);
    check("T4 second line_o", line_o, l);
    last_line = l;
    read_i = 1'b0;
    tick();
    check("T4 resp_o single", resp_o, 1'b0);

    // T5: reset after two write beats, then a normal read
    do_write(32'h0000_3000, rand_line(), 1'b1, 32'hF, 2);
    do_read(32'h0000_3460, rand_line(), 1'b0, 32'h0, 1'b0, 1'b0, ncyc);

    // T6: both requests high; read wins
    do_read(32'h0000_5000, rand_line(), 1'b0, 32'h0, 1'b1, 1'b0, ncyc);

    // Randomized mix
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_read($urandom, rand_line(), 1'b0, 32'h0, 1'b0, 1'b0, ncyc);
      else
        do_write($urandom, rand_line(), 1'b0, 32'h0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
